// File: rtl/pe_dma_mem_responder_pkg.sv
// Shared types and default widths for the PE DMA memory responder and its
// response FIFO.
package pe_dma_mem_pkg;

    localparam int ADDR_W_DEF    = 12;
    localparam int DATA_W_DEF    = 32;
    localparam int TAG_W_DEF     = 4;
    localparam int LEN_W_DEF     = 4;
    localparam int RSP_DEPTH_DEF = 4;

    typedef enum logic {
        OP_READ  = 1'b0,
        OP_WRITE = 1'b1
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RD     = 2'd1,
        ST_WR     = 2'd2,
        ST_WR_RSP = 2'd3
    } state_e;

    typedef struct packed {
        logic [DATA_W_DEF-1:0] data;
        logic [TAG_W_DEF-1:0]  tag;
        logic                  last;
        logic                  is_wr;
        logic                  err;
    } rsp_t;

endpackage

// File: rtl/pe_dma_mem_responder_if.sv
// Request, write-data and response channels between a PE DMA initiator
// (master) and the memory responder (slave).
interface pe_dma_mem_responder_if
    import pe_dma_mem_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int TAG_W  = TAG_W_DEF,
    parameter int LEN_W  = LEN_W_DEF
) ();

    logic              req_valid;
    logic              req_ready;
    logic              req_op;
    logic [ADDR_W-1:0] req_addr;
    logic [LEN_W-1:0]  req_len;
    logic [TAG_W-1:0]  req_tag;

    logic              wr_valid;
    logic              wr_ready;
    logic [DATA_W-1:0] wr_data;
    logic              wr_last;

    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_data;
    logic [TAG_W-1:0]  rsp_tag;
    logic              rsp_last;
    logic              rsp_is_wr;
    logic              rsp_err;

    modport master (
        output req_valid, req_op, req_addr, req_len, req_tag,
        output wr_valid, wr_data, wr_last,
        output rsp_ready,
        input  req_ready, wr_ready,
        input  rsp_valid, rsp_data, rsp_tag, rsp_last, rsp_is_wr, rsp_err
    );

    modport slave (
        input  req_valid, req_op, req_addr, req_len, req_tag,
        input  wr_valid, wr_data, wr_last,
        input  rsp_ready,
        output req_ready, wr_ready,
        output rsp_valid, rsp_data, rsp_tag, rsp_last, rsp_is_wr, rsp_err
    );

endinterface

// File: rtl/pe_dma_mem_responder_rsp_fifo.sv
// Synchronous response FIFO; push and pop may happen in the same cycle.
// Storage is reset so the head reads as zero while empty.
module pe_dma_rsp_fifo
    import pe_dma_mem_pkg::*;
#(
    parameter type T     = rsp_t,
    parameter int  DEPTH = RSP_DEPTH_DEF
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_push,
    input  T                       i_push_data,
    input  logic                   i_pop,
    output T                       o_head,
    output logic                   o_empty,
    output logic [$clog2(DEPTH):0] o_count
);

    localparam int PW = $clog2(DEPTH);

    T              r_mem [DEPTH];
    logic [PW-1:0] r_wptr;
    logic [PW-1:0] r_rptr;
    logic [PW:0]   r_count;
    logic          w_push;
    logic          w_pop;

    assign w_push  = i_push && (r_count != (PW+1)'(DEPTH));
    assign w_pop   = i_pop && (r_count != {(PW+1){1'b0}});
    assign o_head  = r_mem[r_rptr];
    assign o_empty = (r_count == {(PW+1){1'b0}});
    assign o_count = r_count;

    // Storage, pointers and occupancy count.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= {$bits(T){1'b0}};
            end
            r_wptr  <= {PW{1'b0}};
            r_rptr  <= {PW{1'b0}};
            r_count <= {(PW+1){1'b0}};
        end else begin
            if (w_push) begin
                r_mem[r_wptr] <= i_push_data;
                r_wptr        <= r_wptr + PW'(1'b1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + PW'(1'b1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (PW+1)'(1'b1);
                2'b01:   r_count <= r_count - (PW+1)'(1'b1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/pe_dma_mem_responder.sv
// Memory-side DMA responder: services tagged read/write bursts against a
// local word memory and returns read beats and write completions in order.
module pe_dma_mem_responder
    import pe_dma_mem_pkg::*;
#(
    parameter int ADDR_W    = ADDR_W_DEF,
    parameter int DATA_W    = DATA_W_DEF,
    parameter int TAG_W     = TAG_W_DEF,
    parameter int LEN_W     = LEN_W_DEF,
    parameter int RSP_DEPTH = RSP_DEPTH_DEF
) (
    input  logic                   clk,
    input  logic                   reset_poweron_n,
    pe_dma_mem_responder_if.slave  bus
);

    localparam int CW        = $clog2(RSP_DEPTH) + 1;
    localparam int MEM_WORDS = 1 << ADDR_W;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [TAG_W-1:0]  tag;
        logic              last;
        logic              is_wr;
        logic              err;
    } entry_t;

    state_e            r_state;
    state_e            w_state_nx;
    logic [ADDR_W-1:0] r_addr;
    logic [LEN_W-1:0]  r_len;
    logic [LEN_W-1:0]  r_cnt;
    logic [TAG_W-1:0]  r_tag;
    logic              r_err;
    logic              r_inflight;
    logic              r_rd_last;
    logic [TAG_W-1:0]  r_rd_tag;
    logic [DATA_W-1:0] r_rd_data;
    logic [DATA_W-1:0] r_mem [MEM_WORDS];

    logic [CW-1:0]     w_count;
    logic              w_empty;
    logic              w_space;
    logic              w_accept;
    logic              w_rd_issue;
    logic              w_wr_acc;
    logic              w_wr_end;
    logic              w_wr_err;
    logic              w_push;
    logic              w_pop;
    entry_t            w_push_entry;
    entry_t            w_head;

    // Occupancy is taken before any same-cycle pop, so issue is conservative.
    assign w_space = (({1'b0, w_count} + {{CW{1'b0}}, r_inflight}) < (CW+1)'(RSP_DEPTH));

    assign bus.req_ready = (r_state == ST_IDLE);
    assign bus.wr_ready  = (r_state == ST_WR);
    assign bus.rsp_valid = !w_empty;
    assign bus.rsp_data  = w_head.data;
    assign bus.rsp_tag   = w_head.tag;
    assign bus.rsp_last  = w_head.last;
    assign bus.rsp_is_wr = w_head.is_wr;
    assign bus.rsp_err   = w_head.err;
    assign w_pop         = !w_empty && bus.rsp_ready;

    // FSM state register.
    always_ff @(posedge clk or negedge reset_poweron_n) begin
        if (!reset_poweron_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nx;
        end
    end

    // Next state and per-cycle strobes.
    always_comb begin
        w_state_nx = r_state;
        w_accept   = 1'b0;
        w_rd_issue = 1'b0;
        w_wr_acc   = 1'b0;
        w_wr_end   = 1'b0;
        w_wr_err   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.req_valid) begin
                    w_accept   = 1'b1;
                    w_state_nx = (op_e'(bus.req_op) == OP_WRITE) ? ST_WR : ST_RD;
                end else begin
                    w_state_nx = ST_IDLE;
                end
            end
            ST_RD: begin
                if (w_space) begin
                    w_rd_issue = 1'b1;
                    w_state_nx = (r_cnt == r_len) ? ST_IDLE : ST_RD;
                end else begin
                    w_state_nx = ST_RD;
                end
            end
            ST_WR: begin
                if (bus.wr_valid) begin
                    w_wr_acc = 1'b1;
                    // A beat at the declared length closes the burst even without wr_last.
                    if (bus.wr_last || (r_cnt == r_len)) begin
                        w_wr_end   = 1'b1;
                        w_wr_err   = !(bus.wr_last && (r_cnt == r_len));
                        w_state_nx = ST_WR_RSP;
                    end else begin
                        w_state_nx = ST_WR;
                    end
                end else begin
                    w_state_nx = ST_WR;
                end
            end
            ST_WR_RSP: begin
                if (w_space) begin
                    w_state_nx = ST_IDLE;
                end else begin
                    w_state_nx = ST_WR_RSP;
                end
            end
            default: begin
                w_state_nx = ST_IDLE;
            end
        endcase
    end

    // Response push: returning read data, otherwise the write completion.
    always_comb begin
        w_push             = r_inflight || ((r_state == ST_WR_RSP) && w_space);
        w_push_entry.data  = r_rd_data;
        w_push_entry.tag   = r_rd_tag;
        w_push_entry.last  = r_rd_last;
        w_push_entry.is_wr = 1'b0;
        w_push_entry.err   = 1'b0;
        if (!r_inflight) begin
            w_push_entry.data  = {DATA_W{1'b0}};
            w_push_entry.tag   = r_tag;
            w_push_entry.last  = 1'b1;
            w_push_entry.is_wr = 1'b1;
            w_push_entry.err   = r_err;
        end else begin
            w_push_entry.is_wr = 1'b0;
        end
    end

    // Burst context: address, beat counter, tag and read-in-flight tracking.
    always_ff @(posedge clk or negedge reset_poweron_n) begin
        if (!reset_poweron_n) begin
            r_addr     <= {ADDR_W{1'b0}};
            r_len      <= {LEN_W{1'b0}};
            r_cnt      <= {LEN_W{1'b0}};
            r_tag      <= {TAG_W{1'b0}};
            r_err      <= 1'b0;
            r_inflight <= 1'b0;
            r_rd_last  <= 1'b0;
            r_rd_tag   <= {TAG_W{1'b0}};
        end else begin
            r_inflight <= w_rd_issue;
            if (w_accept) begin
                r_addr <= bus.req_addr;
                r_len  <= bus.req_len;
                r_tag  <= bus.req_tag;
                r_cnt  <= {LEN_W{1'b0}};
                r_err  <= 1'b0;
            end
            if (w_rd_issue || w_wr_acc) begin
                r_addr <= r_addr + ADDR_W'(1'b1);
                r_cnt  <= r_cnt + LEN_W'(1'b1);
            end
            if (w_rd_issue) begin
                r_rd_last <= (r_cnt == r_len);
                r_rd_tag  <= r_tag;
            end
            if (w_wr_end) begin
                r_err <= w_wr_err;
            end
        end
    end

    // Word memory with registered read; contents survive reset.
    always_ff @(posedge clk) begin
        if (w_wr_acc) begin
            r_mem[r_addr] <= bus.wr_data;
        end
        if (w_rd_issue) begin
            r_rd_data <= r_mem[r_addr];
        end
    end

    pe_dma_rsp_fifo #(
        .T     (entry_t),
        .DEPTH (RSP_DEPTH)
    ) u_rsp_fifo (
        .i_clk       (clk),
        .i_rst_n     (reset_poweron_n),
        .i_push      (w_push),
        .i_push_data (w_push_entry),
        .i_pop       (w_pop),
        .o_head      (w_head),
        .o_empty     (w_empty),
        .o_count     (w_count)
    );

endmodule

// File: tb/tb_pe_dma_mem_responder.sv
// Directed bench for pe_dma_mem_responder: bursts, wrap, back-pressure,
// write length errors and reset in mid-burst.
module tb_pe_dma_mem_responder;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;
    logic [31:0] wbuf [16];
    logic [31:0] rbuf [16];

    always #5 clk = ~clk;

    pe_dma_mem_responder_if #(.ADDR_W(12), .DATA_W(32), .TAG_W(4), .LEN_W(4)) bus_if ();

    pe_dma_mem_responder dut (
        .clk             (clk),
        .reset_poweron_n (rst_n),
        .bus             (bus_if)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    task automatic send_req(input logic op, input logic [11:0] a, input logic [3:0] l, input logic [3:0] t);
        int k;
        bus_if.req_valid = 1'b1;
        bus_if.req_op    = op;
        bus_if.req_addr  = a;
        bus_if.req_len   = l;
        bus_if.req_tag   = t;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!bus_if.req_ready && k < 100);
        if (!bus_if.req_ready) check("req_ready_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
        bus_if.req_valid = 1'b0;
    endtask

    task automatic do_write(input logic [11:0] a, input logic [3:0] l, input logic [3:0] t,
                            input int nb, input int last_at);
        int k;
        send_req(1'b1, a, l, t);
        for (int i = 0; i < nb; i++) begin
            bus_if.wr_valid = 1'b1;
            bus_if.wr_data  = wbuf[i];
            bus_if.wr_last  = (i == last_at);
            k = 0;
            do begin
                @(negedge clk);
                k++;
            end while (!bus_if.wr_ready && k < 100);
            if (!bus_if.wr_ready) check("wr_ready_timeout", 32'd0, 32'd1);
            @(posedge clk);
            #1;
        end
        bus_if.wr_valid = 1'b0;
        bus_if.wr_last  = 1'b0;
    endtask

    task automatic collect_wr(input logic [3:0] t, input logic e, input int exp_lat);
        int k;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!bus_if.rsp_valid && k < 100);
        check("wc_valid", bus_if.rsp_valid, 32'd1);
        if (exp_lat >= 0) check("wc_latency", k, exp_lat);
        check("wc_tag", bus_if.rsp_tag, t);
        check("wc_err", bus_if.rsp_err, e);
        check("wc_is_wr", bus_if.rsp_is_wr, 32'd1);
        check("wc_last", bus_if.rsp_last, 32'd1);
        check("wc_data", bus_if.rsp_data, 32'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic collect_rd(input int n, input logic [3:0] t, input int exp_lat);
        int k;
        for (int i = 0; i < n; i++) begin
            k = 0;
            do begin
                @(negedge clk);
                k++;
            end while (!bus_if.rsp_valid && k < 100);
            check("rd_valid", bus_if.rsp_valid, 32'd1);
            if (i == 0 && exp_lat >= 0) check("rd_latency", k, exp_lat);
            check("rd_data", bus_if.rsp_data, rbuf[i]);
            check("rd_last", bus_if.rsp_last, (i == n - 1) ? 32'd1 : 32'd0);
            check("rd_tag", bus_if.rsp_tag, t);
            check("rd_is_wr", bus_if.rsp_is_wr, 32'd0);
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus_if.req_valid = 1'b0;
        bus_if.req_op    = 1'b0;
        bus_if.req_addr  = 12'h000;
        bus_if.req_len   = 4'h0;
        bus_if.req_tag   = 4'h0;
        bus_if.wr_valid  = 1'b0;
        bus_if.wr_data   = 32'h0;
        bus_if.wr_last   = 1'b0;
        bus_if.rsp_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_req_ready", bus_if.req_ready, 32'd1);
        check("rst_wr_ready", bus_if.wr_ready, 32'd0);
        check("rst_rsp_valid", bus_if.rsp_valid, 32'd0);
        check("rst_rsp_data", bus_if.rsp_data, 32'd0);
        check("rst_rsp_tag", bus_if.rsp_tag, 32'd0);
        check("rst_rsp_flags", {bus_if.rsp_last, bus_if.rsp_is_wr, bus_if.rsp_err}, 32'd0);
        @(posedge clk);
        #1;

        // Basic 4-beat write then read back with latency checks.
        for (int i = 0; i < 4; i++) wbuf[i] = 32'hA0 + i;
        do_write(12'h010, 4'd3, 4'h5, 4, 3);
        collect_wr(4'h5, 1'b0, 2);
        for (int i = 0; i < 4; i++) rbuf[i] = 32'hA0 + i;
        send_req(1'b0, 12'h010, 4'd3, 4'h6);
        collect_rd(4, 4'h6, 3);

        // Address wrap at the top of memory.
        for (int i = 0; i < 4; i++) wbuf[i] = 32'h11 + i;
        do_write(12'hFFE, 4'd3, 4'h7, 4, 3);
        collect_wr(4'h7, 1'b0, 2);
        for (int i = 0; i < 4; i++) rbuf[i] = 32'h11 + i;
        send_req(1'b0, 12'hFFE, 4'd3, 4'h8);
        collect_rd(4, 4'h8, 3);
        rbuf[0] = 32'h13;
        send_req(1'b0, 12'h000, 4'd0, 4'h9);
        collect_rd(1, 4'h9, 3);

        // 16-beat read under 20 cycles of response back-pressure.
        for (int i = 0; i < 16; i++) wbuf[i] = 32'h200 + i;
        do_write(12'h100, 4'd15, 4'hA, 16, 15);
        collect_wr(4'hA, 1'b0, 2);
        bus_if.rsp_ready = 1'b0;
        send_req(1'b0, 12'h100, 4'd15, 4'hB);
        repeat (20) @(posedge clk);
        #1;
        check("bp_stalled_in_rd", bus_if.req_ready, 32'd0);
        check("bp_rsp_valid", bus_if.rsp_valid, 32'd1);
        check("bp_head_held", bus_if.rsp_data, 32'h200);
        bus_if.rsp_ready = 1'b1;
        for (int i = 0; i < 16; i++) rbuf[i] = 32'h200 + i;
        collect_rd(16, 4'hB, -1);

        // Early wr_last: err=1, remaining words untouched.
        for (int i = 0; i < 4; i++) wbuf[i] = 32'hB0 + i;
        do_write(12'h020, 4'd3, 4'h1, 4, 3);
        collect_wr(4'h1, 1'b0, 2);
        wbuf[0] = 32'hC0;
        wbuf[1] = 32'hC1;
        do_write(12'h020, 4'd3, 4'h2, 2, 1);
        collect_wr(4'h2, 1'b1, 2);
        rbuf[0] = 32'hC0; rbuf[1] = 32'hC1; rbuf[2] = 32'hB2; rbuf[3] = 32'hB3;
        send_req(1'b0, 12'h020, 4'd3, 4'h3);
        collect_rd(4, 4'h3, 3);

        // Missing wr_last: burst closes at length, stray beat refused.
        for (int i = 0; i < 3; i++) wbuf[i] = 32'h90 + i;
        do_write(12'h030, 4'd2, 4'h4, 3, 2);
        collect_wr(4'h4, 1'b0, 2);
        wbuf[0] = 32'hD0;
        wbuf[1] = 32'hD1;
        do_write(12'h030, 4'd1, 4'hC, 2, -1);
        bus_if.wr_valid = 1'b1;
        bus_if.wr_data  = 32'hDE;
        @(negedge clk);
        check("stray_wr_ready", bus_if.wr_ready, 32'd0);
        collect_wr(4'hC, 1'b1, -1);
        bus_if.wr_valid = 1'b0;
        rbuf[0] = 32'hD0; rbuf[1] = 32'hD1; rbuf[2] = 32'h92;
        send_req(1'b0, 12'h030, 4'd2, 4'hD);
        collect_rd(3, 4'hD, 3);

        // Reset in the middle of an 8-beat read.
        send_req(1'b0, 12'h010, 4'd7, 4'hE);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("mid_rst_rsp_valid", bus_if.rsp_valid, 32'd0);
        check("mid_rst_req_ready", bus_if.req_ready, 32'd1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) rbuf[i] = 32'hA0 + i;
        send_req(1'b0, 12'h010, 4'd3, 4'hF);
        collect_rd(4, 4'hF, 3);
        repeat (5) @(negedge clk);
        check("post_drain_empty", bus_if.rsp_valid, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pe_dma_mem_responder.md
# pe_dma_mem_responder

Memory-side responder for the PE DMA-to-memory protocol: accepts DMA read/write burst requests, services them against a local synchronous word memory, and returns read data and write completions on a tagged response channel. It sits at the memory end of each PE's DMA port, opposite the PE DMA initiator, and is used both as the synthesizable local bank and as the array-level memory model.

## Interface
- ADDR_W, 12, word address width; memory holds 2^ADDR_W words
- DATA_W, 32, data word width
- TAG_W, 4, request tag width, echoed on responses
- LEN_W, 4, burst length field width; beats = req_len+1 (1..16)
- RSP_DEPTH, 4, response FIFO entries (power of two, >=2)
- clk  input  1  single clock
- reset_poweron_n  input  1  asynchronous, active-low reset
- req_valid  input  1  request present
- req_ready  output  1  request accepted when valid&ready
- req_op  input  1  0 = read, 1 = write
- req_addr  input  ADDR_W  first word address
- req_len  input  LEN_W  beats minus one
- req_tag  input  TAG_W  request tag
- wr_valid  input  1  write beat present
- wr_ready  output  1  write beat accepted when valid&ready
- wr_data  input  DATA_W  write data
- wr_last  input  1  initiator marks final write beat
- rsp_valid  output  1  response beat present
- rsp_ready  input  1  response consumed when valid&ready
- rsp_data  output  DATA_W  read data; 0 on write completion
- rsp_tag  output  TAG_W  tag of originating request
- rsp_last  output  1  final beat of a read burst; 1 on write completion
- rsp_is_wr  output  1  beat is a write completion
- rsp_err  output  1  write burst length mismatch

## Operation
- FSM states: IDLE, RD, WR, WR_RSP. req_ready = (state==IDLE). Accept latches addr, len, tag, zeroes beat counter; op selects RD or WR.
- RD: issue one memory read per cycle when space = (fifo_count + inflight < RSP_DEPTH), count sampled before any same-cycle pop (conservative). Address increments per issue, wraps modulo 2^ADDR_W. Beat with counter==len issued with last=1, next state IDLE. Read data plus tag/last enters FIFO the cycle after issue.
- WR: wr_ready=1. Each accepted beat writes mem[addr], addr++ (wrapping), counter++.
  - wr_last=1 and counter==len: WR_RSP, err=0.
  - wr_last=1 and counter<len: WR_RSP, err=1; unsent beats never written.
  - counter==len and wr_last=0: beat written, treated as last, WR_RSP, err=1; later stray beats see wr_ready=0 until next write request.
- WR_RSP: push one completion (is_wr=1, last=1, data=0, tag, err) when space; then IDLE.
- wr_valid outside WR is ignored (wr_ready=0). Responses leave strictly in issue order.
- Memory contents are not reset.

## Timing
- Reset values: req_ready=1 (IDLE), wr_ready=0, rsp_valid=0, rsp_data/tag/last/is_wr/err=0, FIFO empty, inflight=0.
- Read accepted in cycle T: first issue T+1, FIFO write end of T+2, rsp_valid at T+3. With rsp_ready held high, one beat per cycle thereafter; 16-beat burst last beat at T+18, req_ready high again at T+17.
- Write accepted at T: wr_ready from T+1; final beat at cycle W, completion rsp_valid at W+2 if space.
- rsp_* hold stable while rsp_valid & !rsp_ready.
- Back-pressure: rsp_ready low stalls issue once fifo_count+inflight reaches RSP_DEPTH; no entry ever dropped.
- Reset asserted mid-burst: immediate return to IDLE, FIFO and inflight flushed, writes already performed retained.

## Structure
- Package pe_dma_mem_pkg: op enum (READ/WRITE), FSM state enum, response struct {data, tag, last, is_wr, err}, default widths as localparams.
- Sub-module pe_dma_rsp_fifo: synchronous FIFO of the response struct, RSP_DEPTH entries, count output, same-cycle push/pop legal.
- Memory is an inferred register array with registered read inside the top module.

## Test plan
- Write addr 0x010 len 3 data 0xA0..0xA3, wr_last on 4th -> one completion tag match, err=0; read addr 0x010 len 3 -> 0xA0..0xA3, rsp_last only on 4th, first rsp_valid 3 cycles after accept.
- Read addr 0xFFE len 3 after writing 0xFFE,0xFFF,0x000,0x001 -> data returned in that wrapped order.
- Read len 15 with rsp_ready low 20 cycles then high -> no more than 4 issues while stalled, all 16 beats delivered in order, none lost.
- Write len 3 with wr_last on beat 2 -> completion err=1; third/fourth addresses unchanged on readback.
- Write len 1 without wr_last -> two words written, completion err=1, extra wr_valid beat ignored (wr_ready=0).
- Assert reset_poweron_n low mid 8-beat read -> rsp_valid=0 and req_ready=1 immediately; new read afterwards returns correct data.
